// File: rtl/packet_tx.sv
// rtl/packet_tx.sv - ping-pong packet buffer that streams 16-word packets as 4 beats of 4 words
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pkt_data[511:0]               16-word packet, word k at bits [32k+31:32k]
//   pkt_valid / pkt_ready         packet handshake; pkt_ready is a register
//   flush                         drop queued packets that have not started
//   tx1..tx4[31:0], en            beat words and beat valid to the receiver
//   busy                          a packet is in transmission or queued
//   exp_sum[31:0], exp_sum_valid  modulo-2^32 sum of the packet's 16 words
// Parameter IPG (0..15): idle cycles inserted after each packet.
// Macro PACKET_TX_CHECKSUM_EN: enables the exp_sum adder; otherwise both
// exp_sum outputs are tied to 0.
module packet_tx #(
  parameter int IPG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] pkt_data,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic         flush,
  output logic [31:0]  tx1,
  output logic [31:0]  tx2,
  output logic [31:0]  tx3,
  output logic [31:0]  tx4,
  output logic         en,
  output logic         busy,
  output logic [31:0]  exp_sum,
  output logic         exp_sum_valid
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = (IPG > 0) ? 4'(IPG - 1) : 4'd0;

  state_t       state, state_nx;
  logic [1:0]   beat, beat_nx;
  logic [3:0]   gap_cnt, gap_nx;
  logic [511:0] slot [2];
  logic         wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic [1:0]   count, count_nx;
  logic         accept, launch, free_slot, start_ok, hold;
  logic [127:0] chunk;

  // count excludes the in-flight packet once its beat 3 has launched, so in
  // IDLE/GAP/last-beat states it holds only packets waiting to start.
  assign start_ok = (count != 2'd0) && !flush;
  assign accept   = pkt_valid && pkt_ready && !flush;
  // In-flight packet still owns its slot after this edge (beat 0 or 1 now).
  assign hold     = (state == SEND) && (beat < 2'd2);

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    gap_nx    = gap_cnt;
    launch    = 1'b0;
    free_slot = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = SEND;
          beat_nx  = 2'd0;
          launch   = 1'b1;
        end
      end
      SEND: begin
        if (beat != 2'd3) begin
          beat_nx   = beat + 2'd1;
          launch    = 1'b1;
          free_slot = (beat == 2'd2);
        end else if (IPG > 0) begin
          state_nx = GAP;
          gap_nx   = GAP_LOAD;
        end else if (start_ok) begin
          beat_nx = 2'd0;
          launch  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt != 4'd0) begin
          gap_nx = gap_cnt - 4'd1;
        end else if (start_ok) begin
          state_nx = SEND;
          beat_nx  = 2'd0;
          launch   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_nx = rd_ptr ^ free_slot;
    if (flush) begin
      count_nx = {1'b0, hold};
      wr_nx    = rd_nx ^ hold;
    end else begin
      count_nx = count + {1'b0, accept} - {1'b0, free_slot};
      wr_nx    = wr_ptr ^ accept;
    end
  end

  assign chunk = slot[rd_ptr][{beat_nx, 7'd0} +: 128];
  assign busy  = (state != IDLE) || (count != 2'd0);

  always_ff @(posedge clk) begin
    if (accept) slot[wr_ptr] <= pkt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= 2'd0;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      beat    <= beat_nx;
      gap_cnt <= gap_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      pkt_ready <= 1'b0;
      en        <= 1'b0;
      tx1       <= 32'd0;
      tx2       <= 32'd0;
      tx3       <= 32'd0;
      tx4       <= 32'd0;
    end else begin
      wr_ptr    <= wr_nx;
      rd_ptr    <= rd_nx;
      count     <= count_nx;
      pkt_ready <= (count_nx < 2'd2);
      en        <= launch;
      tx1       <= launch ? chunk[31:0]   : 32'd0;
      tx2       <= launch ? chunk[63:32]  : 32'd0;
      tx3       <= launch ? chunk[95:64]  : 32'd0;
      tx4       <= launch ? chunk[127:96] : 32'd0;
    end
  end

`ifdef PACKET_TX_CHECKSUM_EN
  logic [31:0] word_sum;
  logic        last_launch;

  // rd_ptr still selects the finishing packet on the edge that launches beat 3.
  assign last_launch = launch && (beat_nx == 2'd3);

  always_comb begin
    word_sum = 32'd0;
    for (int k = 0; k < 16; k++) word_sum = word_sum + slot[rd_ptr][32*k +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sum       <= 32'd0;
      exp_sum_valid <= 1'b0;
    end else begin
      exp_sum_valid <= last_launch;
      if (last_launch) exp_sum <= word_sum;
    end
  end
`else
  assign exp_sum       = 32'd0;
  assign exp_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_packet_tx.sv
// tb/tb_packet_tx.sv - self-checking bench for packet_tx (IPG=0 and IPG=3 instances)
module tb_packet_tx;

`ifdef PACKET_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] pkt_data;
  logic         flush;
  logic         v0, v3;
  logic         r0, en0, busy0, sv0;
  logic         r3, en3, busy3, sv3;
  logic [31:0]  a0, b0, c0, d0, s0;
  logic [31:0]  a3, b3, c3, d3, s3;

  int total = 0;
  int bad = 0;
  logic [127:0] q0[$];
  logic [127:0] q3[$];
  logic [15:0]  e, r, b, sv;
  logic [511:0] pk, pa, pb, pc, pd;

  always #5 clk = ~clk;

  packet_tx #(.IPG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(v0), .pkt_ready(r0),
    .flush(flush), .tx1(a0), .tx2(b0), .tx3(c0), .tx4(d0), .en(en0), .busy(busy0),
    .exp_sum(s0), .exp_sum_valid(sv0)
  );

  packet_tx #(.IPG(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pkt_data(pkt_data), .pkt_valid(v3), .pkt_ready(r3),
    .flush(flush), .tx1(a3), .tx2(b3), .tx3(c3), .tx4(d3), .en(en3), .busy(busy3),
    .exp_sum(s3), .exp_sum_valid(sv3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sum16(input logic [511:0] d);
    logic [31:0] acc = 32'd0;
    for (int k = 0; k < 16; k++) acc = acc + d[32*k +: 32];
    return acc;
  endfunction

  function automatic logic [511:0] rand_pkt();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_pkt(input bit use3, input logic [511:0] d);
    logic [127:0] bt;
    for (int bb = 0; bb < 4; bb++) begin
      bt = {d[128*bb +: 32], d[128*bb+32 +: 32], d[128*bb+64 +: 32], d[128*bb+96 +: 32]};
      if (use3) q3.push_back(bt);
      else q0.push_back(bt);
    end
  endtask

  // Records 16 post-edge samples starting right after the accepting edge.
  task automatic window(input bit use3, input bit two, input logic [511:0] second,
                        input int flush_step, output logic [15:0] we, output logic [15:0] wr,
                        output logic [15:0] wb, output logic [15:0] wsv);
    for (int i = 0; i < 16; i++) begin
      step();
      we[i]  = use3 ? en3 : en0;
      wr[i]  = use3 ? r3 : r0;
      wb[i]  = use3 ? busy3 : busy0;
      wsv[i] = use3 ? sv3 : sv0;
      if (i == 0) begin
        if (two) pkt_data = second;
        else begin v0 = 1'b0; v3 = 1'b0; end
      end
      if (i == 1) begin v0 = 1'b0; v3 = 1'b0; end
      flush = (i == flush_step);
    end
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_ctl"}, 128'({en0, r0, busy0, sv0}), 128'(0));
    chk({tag, "_data"}, {a0, b0, c0, d0}, 128'(0));
    chk({tag, "_sum"}, 128'(s0), 128'(0));
  endtask

  // Scoreboard: every en beat must match the next queued expected beat.
  always @(negedge clk) begin
    if (en0) begin
      chk("beat0_expected", 128'(q0.size() != 0), 128'(1));
      if (q0.size() != 0) chk("beat0_data", {a0, b0, c0, d0}, q0.pop_front());
    end else chk("idle0_tx_zero", {a0, b0, c0, d0}, 128'(0));
    if (en3) begin
      chk("beat3_expected", 128'(q3.size() != 0), 128'(1));
      if (q3.size() != 0) chk("beat3_data", {a3, b3, c3, d3}, q3.pop_front());
    end else chk("idle3_tx_zero", {a3, b3, c3, d3}, 128'(0));
  end

  initial begin
    rst_n = 1'b0; pkt_data = '0; flush = 1'b0; v0 = 1'b0; v3 = 1'b0;
    #1;
    zero_outs("reset");
    chk("reset_dut3", 128'({en3, r3, busy3}), 128'(0));
    step(); step();
    rst_n = 1'b1;
    chk("release_ready_pre", 128'(r0), 128'(0));
    step();
    chk("release_ready", 128'({r0, r3}), 128'(2'b11));

    // single packet, word k = k
    for (int k = 0; k < 16; k++) pk[32*k +: 32] = k;
    pkt_data = pk; v0 = 1'b1; push_pkt(0, pk);
    window(0, 0, '0, -1, e, r, b, sv);
    chk("kk_en", 128'(e), 128'(16'h001E));
    chk("kk_busy", 128'(b), 128'(16'h001F));
    chk("kk_ready", 128'(r), 128'(16'hFFFF));
    chk("kk_sumv", 128'(sv), 128'(16'h0010 & {16{CK}}));
    chk("kk_sum", 128'(s0), CK ? 128'(120) : 128'(0));

    // all ones packet
    pk = '1;
    pkt_data = pk; v0 = 1'b1; push_pkt(0, pk);
    window(0, 0, '0, -1, e, r, b, sv);
    chk("ones_en", 128'(e), 128'(16'h001E));
    chk("ones_sum", 128'(s0), CK ? 128'(32'hFFFF_FFF0) : 128'(0));

    // back-to-back, IPG=0
    pa = rand_pkt(); pb = rand_pkt();
    pkt_data = pa; v0 = 1'b1; push_pkt(0, pa); push_pkt(0, pb);
    window(0, 1, pb, -1, e, r, b, sv);
    chk("b2b_en", 128'(e), 128'(16'h01FE));
    chk("b2b_ready", 128'(r), 128'(16'hFFF1));
    chk("b2b_busy", 128'(b), 128'(16'h01FF));
    chk("b2b_sumv", 128'(sv), 128'(16'h0110 & {16{CK}}));
    chk("b2b_sum", 128'(s0), CK ? 128'(sum16(pb)) : 128'(0));

    // two queued packets, IPG=3
    pkt_data = pa; v3 = 1'b1; push_pkt(1, pa); push_pkt(1, pb);
    window(1, 1, pb, -1, e, r, b, sv);
    chk("ipg3_en", 128'(e), 128'(16'h0F1E));
    chk("ipg3_ready", 128'(r), 128'(16'hFFF1));
    chk("ipg3_busy", 128'(b), 128'(16'h7FFF));
    chk("ipg3_sumv", 128'(sv), 128'(16'h0810 & {16{CK}}));
    chk("ipg3_sum", 128'(s3), CK ? 128'(sum16(pb)) : 128'(0));

    // flush while beat 1 is on the wire, second packet queued and dropped
    pc = rand_pkt(); pd = rand_pkt();
    pkt_data = pc; v0 = 1'b1; push_pkt(0, pc);
    window(0, 1, pd, 2, e, r, b, sv);
    chk("flush_en", 128'(e), 128'(16'h001E));
    chk("flush_ready", 128'(r), 128'(16'hFFF9));
    chk("flush_busy", 128'(b), 128'(16'h001F));
    chk("flush_sum", 128'(s0), CK ? 128'(sum16(pc)) : 128'(0));

    // flush together with pkt_valid drops the new packet
    pkt_data = pd; v0 = 1'b1; flush = 1'b1;
    window(0, 0, '0, -1, e, r, b, sv);
    chk("flushvalid_en", 128'(e), 128'(0));
    chk("flushvalid_busy", 128'(b), 128'(0));

    // reset while beat 2 is on the wire
    pkt_data = pa; v0 = 1'b1; push_pkt(0, pa);
    step(); v0 = 1'b0;
    step(); step(); step();
    chk("midrst_beat2_en", 128'(en0), 128'(1));
    rst_n = 1'b0;
    #1;
    zero_outs("midrst");
    q0.delete();
    step(); step();
    rst_n = 1'b1;
    chk("midrst_ready_pre", 128'(r0), 128'(0));
    window(0, 0, '0, -1, e, r, b, sv);
    chk("midrst_en_after", 128'(e), 128'(0));
    chk("midrst_busy_after", 128'(b), 128'(0));
    chk("midrst_ready_after", 128'(r), 128'(16'hFFFF));

    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q3_drained", 128'(q3.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
